// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//
// Sequences single operations through an external combinational ALU. A command
// is accepted in IDLE and its operands, carry-in and mode are registered onto
// the alu_* outputs. The ALU then has one full ISSUE cycle to settle, after
// which its result, carry-out and overflow are captured into rsp_* and acc.
// The response is held in RESP until the consumer takes it.
//
// Parameters:
//   n  operand/result width in bits
//   m  ALU mode-select width in bits
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_mode/a/b/cin  command payload
//   cmd_use_acc       take operand A from acc (only with ACC_OPERAND_EN)
//   alu_a/b/cin/mode  registered ALU inputs, stable until the next command
//   alu_y/cout/overflow  combinational ALU result
//   rsp_valid/ready   response handshake (valid only in RESP)
//   rsp_y/cout/overflow  captured result, held until the next ISSUE
//   acc               last captured result
//   op_count          completed responses, saturating at all-ones
//
// Build option:
//   ACC_OPERAND_EN  when defined, cmd_use_acc=1 at acceptance loads alu_a
//                   from acc, allowing chained operations. When undefined,
//                   cmd_use_acc is ignored and alu_a always loads cmd_a.
// ----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int unsigned n = 16,
    parameter int unsigned m = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [m-1:0] cmd_mode,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic         cmd_cin,
    input  logic         cmd_use_acc,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic         alu_cin,
    output logic [m-1:0] alu_mode,
    input  logic [n-1:0] alu_y,
    input  logic         alu_cout,
    input  logic         alu_overflow,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_y,
    output logic         rsp_cout,
    output logic         rsp_overflow,
    output logic [n-1:0] acc,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    localparam logic [15:0] CountMax = 16'hFFFF;

    state_e         state_q, state_d;
    logic [n-1:0]   alu_a_q, alu_a_d;
    logic [n-1:0]   alu_b_q, alu_b_d;
    logic           alu_cin_q, alu_cin_d;
    logic [m-1:0]   alu_mode_q, alu_mode_d;
    logic [n-1:0]   rsp_y_q, rsp_y_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic           rsp_ovf_q, rsp_ovf_d;
    logic [n-1:0]   acc_q, acc_d;
    logic [15:0]    op_count_q, op_count_d;
    logic [n-1:0]   operand_a;

    // Operand A source selection at acceptance time.
`ifdef ACC_OPERAND_EN
    assign operand_a = cmd_use_acc ? acc_q : cmd_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign operand_a      = cmd_a;
`endif

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_mode_d = alu_mode_q;
        rsp_y_d    = rsp_y_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        acc_d      = acc_q;
        op_count_d = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    alu_a_d    = operand_a;
                    alu_b_d    = cmd_b;
                    alu_cin_d  = cmd_cin;
                    alu_mode_d = cmd_mode;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                // ALU inputs have been stable for a full cycle; capture.
                rsp_y_d    = alu_y;
                rsp_cout_d = alu_cout;
                rsp_ovf_d  = alu_overflow;
                acc_d      = alu_y;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    if (op_count_q != CountMax) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_mode_q <= '0;
            rsp_y_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            acc_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_mode_q <= alu_mode_d;
            rsp_y_q    <= rsp_y_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
            acc_q      <= acc_d;
            op_count_q <= op_count_d;
        end
    end

    // Handshake flags are pure decodes of the registered state.
    assign cmd_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_cin      = alu_cin_q;
    assign alu_mode     = alu_mode_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_overflow = rsp_ovf_q;
    assign acc          = acc_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. A small combinational ALU model sits
// on the alu_* outputs. Table-driven single operations, then hand-written
// sequences for reset in ISSUE, back-pressure, accumulator chaining and
// op_count saturation. Inputs change and outputs are sampled on the falling
// edge.
// ALU model modes: 0 a<<1, 4 a+b+cin, 5 a-b-cin (cout=borrow), 6 a&b,
// 14 pass b, others a^b.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_mode;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_cin;
    logic        cmd_use_acc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [3:0]  alu_mode;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic        rsp_cout;
    logic        rsp_overflow;
    logic [15:0] acc;
    logic [15:0] op_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    alu_sequencer #(
        .n(16),
        .m(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_mode    (alu_mode),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .alu_overflow(alu_overflow),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_cout    (rsp_cout),
        .rsp_overflow(rsp_overflow),
        .acc         (acc),
        .op_count    (op_count)
    );

    // Reference ALU.
    logic [16:0] sum17;
    always_comb begin
        sum17        = 17'd0;
        alu_y        = 16'h0000;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_mode)
            4'd0: begin
                alu_y        = {alu_a[14:0], 1'b0};
                alu_cout     = alu_a[15];
                alu_overflow = alu_a[15] ^ alu_a[14];
            end
            4'd4: begin
                sum17        = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
                alu_y        = sum17[15:0];
                alu_cout     = sum17[16];
                alu_overflow = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
            end
            4'd5: begin
                alu_y        = alu_a - alu_b - {15'd0, alu_cin};
                alu_cout     = ({1'b0, alu_b} + {16'd0, alu_cin}) > {1'b0, alu_a};
                alu_overflow = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
            end
            4'd6:    alu_y = alu_a & alu_b;
            4'd14:   alu_y = alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full command/response transaction with immediate consumption.
    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [3:0] mode, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic use_acc,
                          input logic [15:0] ea, input logic [15:0] ey,
                          input logic ec, input logic eo);
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_a       = a;
        cmd_b       = b;
        cmd_cin     = cin;
        cmd_use_acc = use_acc;
        rsp_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, " issue cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        check({tag, " issue rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " alu_a"}, {16'd0, alu_a}, {16'd0, ea});
        check({tag, " alu_b"}, {16'd0, alu_b}, {16'd0, b});
        check({tag, " alu_mode"}, {28'd0, alu_mode}, {28'd0, mode});
        check({tag, " alu_cin"}, {31'd0, alu_cin}, {31'd0, cin});
        @(posedge clk);
        @(negedge clk);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, " rsp_y"}, {16'd0, rsp_y}, {16'd0, ey});
        check({tag, " rsp_cout"}, {31'd0, rsp_cout}, {31'd0, ec});
        check({tag, " rsp_overflow"}, {31'd0, rsp_overflow}, {31'd0, eo});
        check({tag, " acc"}, {16'd0, acc}, {16'd0, ey});
        check({tag, " op_count pre"}, {16'd0, op_count}, {16'd0, exp_cnt});
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        check({tag, " op_count post"}, {16'd0, op_count}, {16'd0, exp_cnt});
        check({tag, " idle cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, " idle rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " rsp_y held"}, {16'd0, rsp_y}, {16'd0, ey});
        check({tag, " alu_a held"}, {16'd0, alu_a}, {16'd0, ea});
    endtask

    typedef struct {
        string       name;
        logic [3:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] y;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"add_ovf",   4'd4,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1] = '{"sub_ovf",   4'd5,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[2] = '{"add_carry", 4'd4,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{"add_cin",   4'd4,  16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
        vecs[4] = '{"and",       4'd6,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0};
        vecs[5] = '{"xor_m15",   4'd15, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0};
        vecs[6] = '{"pass_b",    4'd14, 16'hDEAD, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0};

        rst         = 1'b1;
        cmd_valid   = 1'b1;  // reset must win over a pending command
        cmd_mode    = 4'd4;
        cmd_a       = 16'h1234;
        cmd_b       = 16'h4321;
        cmd_cin     = 1'b1;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        exp_cnt     = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset alu_a", {16'd0, alu_a}, 32'd0);
        check("reset alu_cin", {31'd0, alu_cin}, 32'd0);
        check("reset rsp_y", {16'd0, rsp_y}, 32'd0);
        check("reset acc", {16'd0, acc}, 32'd0);
        check("reset op_count", {16'd0, op_count}, 32'd0);

        // Reset while in ISSUE discards the pending response.
        cmd_valid = 1'b1;
        cmd_mode  = 4'd4;
        cmd_a     = 16'h0100;
        cmd_b     = 16'h0023;
        cmd_cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b0;
        check("rst_issue cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_issue rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_issue acc", {16'd0, acc}, 32'd0);
        check("rst_issue rsp_y", {16'd0, rsp_y}, 32'd0);
        check("rst_issue op_count", {16'd0, op_count}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_issue stays idle", {31'd0, rsp_valid}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].a, vecs[i].y, vecs[i].cout, vecs[i].ovf);
        end

        // Back-pressure: response held five cycles while a new command is offered.
        cmd_valid = 1'b1;
        cmd_mode  = 4'd4;
        cmd_a     = 16'h0010;
        cmd_b     = 16'h0020;
        cmd_cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_mode = 4'd6;
        cmd_a    = 16'hAAAA;
        cmd_b    = 16'h5555;
        cmd_cin  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp rsp_y", {16'd0, rsp_y}, 32'h0030);
            check("bp acc", {16'd0, acc}, 32'h0030);
            check("bp alu_a", {16'd0, alu_a}, 32'h0010);
            check("bp alu_mode", {28'd0, alu_mode}, 32'd4);
            check("bp op_count", {16'd0, op_count}, {16'd0, exp_cnt});
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        check("bp op_count after", {16'd0, op_count}, {16'd0, exp_cnt});
        check("bp idle", {31'd0, cmd_ready}, 32'd1);
        check("bp alu_b not latched", {16'd0, alu_b}, 32'h0020);
        @(negedge clk);
        check("bp no stray issue", {31'd0, cmd_ready}, 32'd1);

        // Chained operation through the accumulator.
        run_op("chain0", 4'd14, 16'h1234, 16'h0005, 1'b0, 1'b0,
               16'h1234, 16'h0005, 1'b0, 1'b0);
`ifdef ACC_OPERAND_EN
        run_op("chain1", 4'd0, 16'h0003, 16'h0000, 1'b0, 1'b1,
               16'h0005, 16'h000A, 1'b0, 1'b0);
`else
        run_op("chain1", 4'd0, 16'h0003, 16'h0000, 1'b0, 1'b1,
               16'h0003, 16'h0006, 1'b0, 1'b0);
`endif

        // Saturation: 65536 back-to-back handshakes, three cycles each.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        cmd_valid   = 1'b1;
        cmd_mode    = 4'd6;
        cmd_a       = 16'hFFFF;
        cmd_b       = 16'hFFFF;
        cmd_cin     = 1'b0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        repeat (3 * 65534) @(posedge clk);
        @(negedge clk);
        check("sat 65534", {16'd0, op_count}, 32'hFFFE);
        check("sat rsp_y", {16'd0, rsp_y}, 32'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat 65535", {16'd0, op_count}, 32'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat 65536", {16'd0, op_count}, 32'hFFFF);
        check("sat idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
